// File: rtl/bram_pkg.sv
// bram_pkg: shared write-mode codes and byte-lane merge for the dual-port byte RAM
package bram_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   // Widest word byte_merge can handle; callers zero-extend narrower words.
   localparam int MAX_DW = 128;

   // Lane l of the result comes from new_w when we[l] is set, else from old_w.
   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_DW-1:0] we,
      input int                bw
   );
      logic [MAX_DW-1:0] m;
      logic [MAX_DW-1:0] w;
      logic [MAX_DW-1:0] lane;
      m    = '0;
      w    = we;
      lane = (MAX_DW'(1) << bw) - MAX_DW'(1);
      for (int l = 0; l < MAX_DW; l++) begin
         if (w[0]) m = m | (lane << (l * bw));
         w = w >> 1;
      end
      return (old_w & ~m) | (new_w & m);
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: per-port read output register and valid strobe, 1 or 2 stages
//   clk, rst         clock, synchronous active-high reset
//   acc_i            an access was issued this cycle (valid pulses RL cycles later)
//   load_i           the access updates dout (low for NO_CHANGE writes)
//   data_i           word to present for this access
//   dout_o, valid_o  registered read data and its one-cycle strobe
module bram_rd_pipe #(
   parameter int DW = 32,
   parameter int RL = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acc_i,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] dout_o,
   output logic          valid_o
);

   logic [DW-1:0] d1_q;
   logic [DW-1:0] d1_d;
   logic          v1_q;

   assign d1_d = (acc_i && load_i) ? data_i : d1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         d1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         d1_q <= d1_d;
         v1_q <= acc_i;
      end
   end

   if (RL == 2) begin : g_rl2
      // Second stage copies the first every cycle; holding is inherited from d1_q.
      logic [DW-1:0] d2_q;
      logic          v2_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            d2_q <= '0;
            v2_q <= 1'b0;
         end else begin
            d2_q <= d1_q;
            v2_q <= v1_q;
         end
      end
      assign dout_o  = d2_q;
      assign valid_o = v2_q;
   end else begin : g_rl1
      assign dout_o  = d1_q;
      assign valid_o = v1_q;
   end

endmodule

// File: rtl/bram_dp_be.sv
// bram_dp_be: true dual-port RAM with byte write enables, write modes and 1/2-cycle read latency
//   clk, rst                      shared clock, synchronous active-high reset (memory not cleared)
//   a_en, a_we, a_addr, a_din     port A request: read, or byte-masked write when any a_we bit set
//   a_dout, a_dout_valid          port A read data and one-cycle strobe
//   b_*                           port B, same set; A wins per lane on same-address writes
module bram_dp_be
   import bram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 10,
   parameter int SIZE         = 1024,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             a_en,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
   input  logic [ADDR_WIDTH-1:0]            a_addr,
   input  logic [DATA_WIDTH-1:0]            a_din,
   output logic [DATA_WIDTH-1:0]            a_dout,
   output logic                             a_dout_valid,
   input  logic                             b_en,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_we,
   input  logic [ADDR_WIDTH-1:0]            b_addr,
   input  logic [DATA_WIDTH-1:0]            b_din,
   output logic [DATA_WIDTH-1:0]            b_dout,
   output logic                             b_dout_valid
);

   localparam int NB  = DATA_WIDTH / BYTE_WIDTH;
   localparam int AI  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] SZ = AW1'(SIZE);

   if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
      $error("bram_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and at most MAX_DW");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("bram_dp_be: READ_LATENCY must be 1 or 2");
   end
   if (WRITE_MODE != WM_READ_FIRST && WRITE_MODE != WM_WRITE_FIRST && WRITE_MODE != WM_NO_CHANGE) begin : g_bad_mode
      $error("bram_dp_be: WRITE_MODE must be 0, 1 or 2");
   end

   function automatic logic [DATA_WIDTH-1:0] merge_w(
      input logic [DATA_WIDTH-1:0] o,
      input logic [DATA_WIDTH-1:0] n,
      input logic [NB-1:0]         we
   );
      return DATA_WIDTH'(byte_merge(MAX_DW'(o), MAX_DW'(n), MAX_DW'(we), BYTE_WIDTH));
   endfunction

   logic [DATA_WIDTH-1:0] mem [SIZE];

   logic                  a_in, b_in;
   logic                  a_wr, b_wr, coll;
   logic [AI-1:0]         a_idx, b_idx;
   logic [NB-1:0]         b_we_eff;
   logic [DATA_WIDTH-1:0] a_old, b_old;
   logic [DATA_WIDTH-1:0] a_new, b_new;
   logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
   logic                  a_load, b_load;

   assign a_in  = {1'b0, a_addr} < SZ;
   assign b_in  = {1'b0, b_addr} < SZ;
   assign a_idx = a_addr[AI-1:0];
   assign b_idx = b_addr[AI-1:0];
   assign a_old = a_in ? mem[a_idx] : '0;
   assign b_old = b_in ? mem[b_idx] : '0;

   // Writes in a reset cycle or outside the implemented range never reach the array.
   assign a_wr = a_en && !rst && a_in && |a_we;
   assign b_wr = b_en && !rst && b_in && |b_we;
   assign coll = a_wr && b_wr && (a_addr == b_addr);

   // On a same-address double write, A's word is layered over B's so one store carries both.
   assign b_we_eff = coll ? (b_we & ~a_we) : b_we;
   assign b_new    = merge_w(b_old, b_din, b_we_eff);
   assign a_new    = merge_w(coll ? b_new : a_old, a_din, a_we);

   always_ff @(posedge clk) begin
      if (b_wr && !coll) mem[b_idx] <= b_new;
      if (a_wr) mem[a_idx] <= a_new;
   end

   // Read data uses the pre-edge array, so a reader colliding with the other port's write sees the old word.
   assign a_rdata = !a_in ? '0 : (|a_we && WRITE_MODE == WM_WRITE_FIRST) ? merge_w(a_old, a_din, a_we) : a_old;
   assign b_rdata = !b_in ? '0 : (|b_we && WRITE_MODE == WM_WRITE_FIRST) ? merge_w(b_old, b_din, b_we) : b_old;
   assign a_load  = !(|a_we && WRITE_MODE == WM_NO_CHANGE);
   assign b_load  = !(|b_we && WRITE_MODE == WM_NO_CHANGE);

   bram_rd_pipe #(.DW(DATA_WIDTH), .RL(READ_LATENCY)) u_a_pipe (
      .clk     (clk),
      .rst     (rst),
      .acc_i   (a_en),
      .load_i  (a_load),
      .data_i  (a_rdata),
      .dout_o  (a_dout),
      .valid_o (a_dout_valid)
   );

   bram_rd_pipe #(.DW(DATA_WIDTH), .RL(READ_LATENCY)) u_b_pipe (
      .clk     (clk),
      .rst     (rst),
      .acc_i   (b_en),
      .load_i  (b_load),
      .data_i  (b_rdata),
      .dout_o  (b_dout),
      .valid_o (b_dout_valid)
   );

endmodule
